// File: rtl/io_echo_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_echo_master_pkg
// Description : Shared IO-space constants for the UART IOInterface bus and
//               state encodings for the hardware echo master.
// Revision    : 1.0 - initial release
// ============================================================================
package io_echo_master_pkg;

    // Register offsets relative to the MMIO base address
    localparam logic [31:0] c_ofs_status = 32'h0000_0000;
    localparam logic [31:0] c_ofs_rx     = 32'h0000_0004;
    localparam logic [31:0] c_ofs_tx     = 32'h0000_0008;

    // Bit positions inside the status word
    localparam int c_bit_tx_ready = 0;
    localparam int c_bit_rx_valid = 1;

    // Byte-lane enable for a single-byte store to the TX data register
    localparam logic [3:0] c_store_byte0 = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_POLL_RX  = 3'd1,
        ST_READ_RX  = 3'd2,
        ST_POLL_TX  = 3'd3,
        ST_WRITE_TX = 3'd4
    } echo_state_t;

endpackage
`default_nettype wire

// File: rtl/io_load_waiter.sv
`default_nettype none
// ============================================================================
// Module      : io_load_waiter
// Description : Counts the cycles a load request has been held on the IO bus
//               and strobes when the load data is ready to be sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module io_load_waiter #(
    parameter int unsigned LOAD_WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    output logic o_sample
);

    localparam int unsigned         c_cnt_w    = $clog2(LOAD_WAIT + 1);
    localparam logic [c_cnt_w-1:0]  c_wait_end = c_cnt_w'(LOAD_WAIT);

    logic [c_cnt_w-1:0] r_cnt;

    // Strobe once the request has been visible for LOAD_WAIT full cycles
    assign o_sample = i_active && (r_cnt == c_wait_end);

    // Restart the count on every new load (sample ends the current one)
    always_ff @(posedge clk) begin
        if (rst || !i_active || o_sample) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_echo_master.sv
`default_nettype none
// ============================================================================
// Module      : io_echo_master
// Description : CPU-less bus initiator for the UART IOInterface. Polls the
//               status register and copies every received byte (optionally
//               XOR-transformed) back to the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module io_echo_master #(
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int unsigned COUNT_W   = 16,
    parameter logic [7:0]  XOR_MASK  = 8'h00,
    parameter int unsigned LOAD_WAIT = 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enable,
    output logic [31:0]        Addr,
    output logic [31:0]        rd2,
    output logic [3:0]         IO_trans,
    output logic               IO_recv,
    input  logic [31:0]        Received,
    output logic               Busy,
    output logic [COUNT_W-1:0] ByteCount,
    output logic [7:0]         LastByte
);

    import io_echo_master_pkg::*;

    echo_state_t r_state;
    echo_state_t w_state_nxt;
    logic [7:0]  r_byte;
    logic [7:0]  w_byte_nxt;
    logic        w_load_active;
    logic        w_sample;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_rd2_nxt;
    logic [3:0]  w_trans_nxt;
    logic        w_recv_nxt;
    logic        w_unused_rcv;

    // Upper load-data bits carry nothing this block cares about
    assign w_unused_rcv = ^Received[31:8];

    assign w_load_active = (r_state == ST_POLL_RX) ||
                           (r_state == ST_READ_RX) ||
                           (r_state == ST_POLL_TX);

    io_load_waiter #(
        .LOAD_WAIT (LOAD_WAIT)
    ) u_load_waiter (
        .clk      (Clock),
        .rst      (Reset),
        .i_active (w_load_active),
        .o_sample (w_sample)
    );

    // State and latched-byte registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_byte  <= w_byte_nxt;
        end
    end

    // Next-state logic; status/data are only looked at on the sample strobe
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        case (r_state)
            ST_IDLE: begin
                if (Enable) w_state_nxt = ST_POLL_RX;
            end
            ST_POLL_RX: begin
                if (w_sample) begin
                    if (Received[c_bit_rx_valid]) w_state_nxt = ST_READ_RX;
                    else if (!Enable)             w_state_nxt = ST_IDLE;
                end
            end
            ST_READ_RX: begin
                // Single pass through here per byte: this load pops the RX FIFO
                if (w_sample) begin
                    w_byte_nxt  = Received[7:0] ^ XOR_MASK;
                    w_state_nxt = ST_POLL_TX;
                end
            end
            ST_POLL_TX: begin
                if (w_sample && Received[c_bit_tx_ready]) w_state_nxt = ST_WRITE_TX;
            end
            ST_WRITE_TX: begin
                w_state_nxt = Enable ? ST_POLL_RX : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus outputs decoded from the upcoming state so they are registered
    always_comb begin
        w_addr_nxt  = MMIO_BASE + c_ofs_status;
        w_rd2_nxt   = 32'h0000_0000;
        w_trans_nxt = 4'b0000;
        w_recv_nxt  = 1'b0;
        case (w_state_nxt)
            ST_POLL_RX, ST_POLL_TX: begin
                w_recv_nxt = 1'b1;
            end
            ST_READ_RX: begin
                w_addr_nxt = MMIO_BASE + c_ofs_rx;
                w_recv_nxt = 1'b1;
            end
            ST_WRITE_TX: begin
                w_addr_nxt  = MMIO_BASE + c_ofs_tx;
                w_rd2_nxt   = {24'h00_0000, w_byte_nxt};
                w_trans_nxt = c_store_byte0;
            end
            default: begin
            end
        endcase
    end

    // Registered bus outputs and status counters
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Addr      <= MMIO_BASE;
            rd2       <= 32'h0000_0000;
            IO_trans  <= 4'b0000;
            IO_recv   <= 1'b0;
            Busy      <= 1'b0;
            ByteCount <= '0;
            LastByte  <= 8'h00;
        end else begin
            Addr     <= w_addr_nxt;
            rd2      <= w_rd2_nxt;
            IO_trans <= w_trans_nxt;
            IO_recv  <= w_recv_nxt;
            Busy     <= (w_state_nxt != ST_IDLE);
            // Counters move together with the TX store becoming visible
            if (w_state_nxt == ST_WRITE_TX) begin
                ByteCount <= ByteCount + 1'b1;
                LastByte  <= w_byte_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_echo_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_io_echo_master
// Description : Two echo masters (plain / XOR 0x20 with LOAD_WAIT 2) driving
//               a behavioural IOInterface + host UART model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_echo_master;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        int         dut;
        logic [7:0] tx;
        logic [7:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        en    [2];
    logic [31:0] addr  [2];
    logic [31:0] rd2   [2];
    logic [31:0] rcv   [2];
    logic [3:0]  trans [2];
    logic        recv  [2];
    logic        busy  [2];
    logic [7:0]  last  [2];
    logic [3:0]  bc0;
    logic [15:0] bc1;

    // Host/IOInterface model state
    logic [7:0]  rx_mem [2][256];
    int          rx_head   [2] = '{0, 0};
    int          rx_tail   [2] = '{0, 0};
    logic        tx_ready  [2] = '{1'b1, 1'b1};
    logic        prev_rx   [2] = '{1'b0, 1'b0};
    int          store_cnt [2] = '{0, 0};
    int          recv_cnt  [2] = '{0, 0};
    int          last_cyc  [2] = '{0, 0};
    int          gap       [2] = '{0, 0};
    int          exp_bc    [2] = '{0, 0};
    logic [7:0]  exp_last  [2] = '{8'h00, 8'h00};
    int          mutex_err = 0;
    int          fifo_err  = 0;
    int          cyc       = 0;
    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    io_echo_master #(
        .MMIO_BASE(BASE), .COUNT_W(4), .XOR_MASK(8'h00), .LOAD_WAIT(1)
    ) dut0 (
        .Clock(clk), .Reset(rst[0]), .Enable(en[0]), .Addr(addr[0]), .rd2(rd2[0]),
        .IO_trans(trans[0]), .IO_recv(recv[0]), .Received(rcv[0]), .Busy(busy[0]),
        .ByteCount(bc0), .LastByte(last[0])
    );

    io_echo_master #(
        .MMIO_BASE(BASE), .COUNT_W(16), .XOR_MASK(8'h20), .LOAD_WAIT(2)
    ) dut1 (
        .Clock(clk), .Reset(rst[1]), .Enable(en[1]), .Addr(addr[1]), .rd2(rd2[1]),
        .IO_trans(trans[1]), .IO_recv(recv[1]), .Received(rcv[1]), .Busy(busy[1]),
        .ByteCount(bc1), .LastByte(last[1])
    );

    // IOInterface read mux: status carries junk in the unused upper bits
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rcv[i] = 32'h0000_0000;
            if (addr[i] == BASE)
                rcv[i] = {30'h2A5A_5A5A, (rx_head[i] != rx_tail[i]), tx_ready[i]};
            else if (addr[i] == BASE + 32'h4)
                rcv[i] = {24'hC3C3C3, rx_mem[i][rx_head[i][7:0]]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Bus monitor / UART model, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                logic       cur_rx;
                logic       has;
                logic [7:0] e;
                has = 1'b0;
                e   = 8'h00;
                if (recv[i] && trans[i] != 4'b0000) mutex_err++;
                if (recv[i]) recv_cnt[i]++;
                cur_rx = recv[i] && (addr[i] == BASE + 32'h4);
                if (prev_rx[i] && !cur_rx) begin
                    if (rx_head[i] == rx_tail[i]) fifo_err++;
                    else rx_head[i]++;
                end
                prev_rx[i] = cur_rx;
                if (trans[i] != 4'b0000) begin
                    store_cnt[i]++;
                    gap[i]      = cyc - last_cyc[i];
                    last_cyc[i] = cyc;
                    chk("store_addr", addr[i], BASE + 32'h8);
                    chk("store_be", 32'(trans[i]), 32'h1);
                    if (i == 0) begin
                        has = (exp_q0.size() != 0);
                        if (has) e = exp_q0.pop_front();
                    end else begin
                        has = (exp_q1.size() != 0);
                        if (has) e = exp_q1.pop_front();
                    end
                    if (!has) begin
                        checks++;
                        $display("FAIL unexpected_store dut%0d: got store of %h required none", i, rd2[i]);
                    end else begin
                        chk("echo_byte", rd2[i], {24'h0, e});
                    end
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] b, input logic [7:0] e, input logic echoed);
        rx_mem[i][rx_tail[i][7:0]] = b;
        rx_tail[i]++;
        if (echoed) begin
            if (i == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            exp_bc[i]++;
            exp_last[i] = e;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input int i, input int budget);
        int n;
        int left;
        n    = 0;
        left = (i == 0) ? exp_q0.size() : exp_q1.size();
        while (left != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            left = (i == 0) ? exp_q0.size() : exp_q1.size();
        end
        checks++;
        if (left == 0) passes++;
        else $display("FAIL drain_timeout dut%0d: got %0d bytes outstanding required 0", i, left);
    endtask

    task automatic chk_counts(input int i);
        if (i == 0) chk("bytecount0", 32'(bc0), 32'(exp_bc[0] & 15));
        else        chk("bytecount1", 32'(bc1), 32'(exp_bc[1] & 16'hFFFF));
        chk("lastbyte", 32'(last[i]), 32'(exp_last[i]));
    endtask

    task automatic chk_reset_outputs(input int i);
        chk("rst_addr", addr[i], BASE);
        chk("rst_rd2", rd2[i], 32'h0);
        chk("rst_trans", 32'(trans[i]), 32'h0);
        chk("rst_recv", 32'(recv[i]), 32'h0);
        chk("rst_busy", 32'(busy[i]), 32'h0);
        chk("rst_last", 32'(last[i]), 32'h0);
        if (i == 0) chk("rst_bc0", 32'(bc0), 32'h0);
        else        chk("rst_bc1", 32'(bc1), 32'h0);
    endtask

    task automatic wait_bus(input int i, input logic [31:0] a, input string name);
        int n;
        n = 0;
        while (!(recv[i] && addr[i] == a) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(n < 60), 32'h1);
    endtask

    vec_t vecs[9];

    initial begin
        int sc;
        vecs[0] = '{0, 8'hAA, 8'hAA};
        vecs[1] = '{1, 8'h61, 8'h41};
        vecs[2] = '{1, 8'h62, 8'h42};
        vecs[3] = '{1, 8'h63, 8'h43};
        vecs[4] = '{0, 8'h00, 8'h00};
        vecs[5] = '{0, 8'hFF, 8'hFF};
        vecs[6] = '{1, 8'h20, 8'h00};
        vecs[7] = '{1, 8'hDF, 8'hFF};
        vecs[8] = '{0, 8'h3C, 8'h3C};

        // Reset with Enable low: reset values, then idle without any loads
        rst[0] = 1'b1; rst[1] = 1'b1; en[0] = 1'b0; en[1] = 1'b0;
        wait_cycles(2);
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst[0] = 1'b0; rst[1] = 1'b0;
        wait_cycles(5);
        chk("idle_no_recv0", 32'(recv_cnt[0]), 32'h0);
        chk("idle_no_recv1", 32'(recv_cnt[1]), 32'h0);
        chk("idle_busy0", 32'(busy[0]), 32'h0);

        // Table of single-byte echoes on both masters
        en[0] = 1'b1; en[1] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            send(vecs[k].dut, vecs[k].tx, vecs[k].exp, 1'b1);
            wait_drain(vecs[k].dut, 80);
            chk_counts(vecs[k].dut);
        end

        // Back-to-back bytes on the XOR master: in order, 10-cycle spacing
        send(1, 8'h61, 8'h41, 1'b1);
        send(1, 8'h62, 8'h42, 1'b1);
        send(1, 8'h63, 8'h43, 1'b1);
        wait_drain(1, 120);
        chk_counts(1);
        chk("gap_wait2", 32'(gap[1]), 32'd10);

        // Enable drop while merely polling: back to idle
        en[1] = 1'b0;
        wait_cycles(6);
        chk("poll_drop_busy", 32'(busy[1]), 32'h0);

        // Enable drop after the RX read has started: byte still echoed once
        send(0, 8'h5A, 8'h5A, 1'b1);
        wait_bus(0, BASE + 32'h4, "read_rx_seen");
        wait_cycles(1);
        en[0] = 1'b0;
        wait_drain(0, 60);
        chk_counts(0);
        wait_cycles(3);
        chk("drop_busy", 32'(busy[0]), 32'h0);
        chk("drop_recv", 32'(recv[0]), 32'h0);
        chk("drop_fifo_empty", 32'(rx_tail[0] - rx_head[0]), 32'h0);

        // Reset while waiting for TX ready: latched byte discarded
        tx_ready[0] = 1'b0;
        en[0] = 1'b1;
        send(0, 8'h33, 8'h00, 1'b0);
        wait_bus(0, BASE + 32'h4, "read_rx_seen2");
        wait_bus(0, BASE, "poll_tx_seen");
        wait_cycles(4);
        chk("poll_tx_busy", 32'(busy[0]), 32'h1);
        sc = store_cnt[0];
        rst[0] = 1'b1;
        en[0]  = 1'b0;
        wait_cycles(1);
        chk_reset_outputs(0);
        tx_ready[0] = 1'b1;
        wait_cycles(1);
        rst[0] = 1'b0;
        exp_bc[0]   = 0;
        exp_last[0] = 8'h00;
        wait_cycles(10);
        chk("no_store_after_reset", 32'(store_cnt[0] - sc), 32'h0);
        chk_counts(0);

        // 17 bytes through the 4-bit counter: wraps to 1, 7 cycles per byte
        en[0] = 1'b1;
        for (int k = 0; k < 17; k++) send(0, 8'h10 + 8'(k), 8'h10 + 8'(k), 1'b1);
        wait_drain(0, 17 * 7 + 60);
        chk_counts(0);
        chk("gap_wait1", 32'(gap[0]), 32'd7);

        wait_cycles(4);
        chk("store_load_exclusive", 32'(mutex_err), 32'h0);
        chk("rx_pop_once", 32'(fifo_err), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
